// File: rtl/decimal_to_bcd_300.sv
// decimal_to_bcd_300: packs a stream of decimal digits into a NUM_DIGITS-wide
// BCD frame. Digit k lands in bcd[4k+3:4k]; the full frame is held on bcd
// with bcd_valid until the consumer acknowledges it.
// Optional feature: define DEC2BCD_ERR_EN to enable the sticky invalid-digit
// flag on err; without it err is tied low and no error flop exists.
module decimal_to_bcd_300 #(
  parameter int NUM_DIGITS = 300,
  parameter int IDX_W      = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [3:0]              in_dec,
  output logic                    in_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    bcd_valid,
  input  logic                    out_ack,
  output logic [IDX_W-1:0]        digit_cnt,
  output logic                    err
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_bad;
  logic                    w_release;
  logic [3:0]              w_digit;

  assign in_ready  = (r_state == FILL) && !clr;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = w_accept && (r_cnt == LAST_IDX);
  assign w_release = (r_state == FULL) && out_ack;
  assign w_bad     = (in_dec > 4'd9);
  assign w_digit   = w_bad ? 4'd0 : in_dec;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= FILL;
    else          r_state <= w_next;
  end

  // Next state: clr dominates both the final accept and the acknowledge
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_last)  w_next = FULL;
        FULL:    if (out_ack) w_next = FILL;
        default: w_next = FILL;
      endcase
    end
  end

  // Digit counter: saturates at NUM_DIGITS because accepts stop in FULL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_cnt <= '0;
    else if (clr)       r_cnt <= '0;
    else if (w_release) r_cnt <= '0;
    else if (w_accept)  r_cnt <= r_cnt + 1'b1;
  end

  // Frame storage: decoded write-enable per digit slot; acknowledge leaves old data in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd <= '0;
    end else if (clr) begin
      r_bcd <= '0;
    end else if (w_accept) begin
      for (int unsigned k = 0; k < unsigned'(NUM_DIGITS); k++) begin
        if (r_cnt == IDX_W'(k)) r_bcd[4*k +: 4] <= w_digit;
      end
    end
  end

`ifdef DEC2BCD_ERR_EN
  logic r_err;

  // Sticky invalid-digit flag, cleared with the frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_err <= 1'b0;
    else if (clr)                r_err <= 1'b0;
    else if (w_release)          r_err <= 1'b0;
    else if (w_accept && w_bad)  r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign bcd       = r_bcd;
  assign bcd_valid = (r_state == FULL);
  assign digit_cnt = r_cnt;

endmodule

// File: doc/decimal_to_bcd_300.md
DECIMAL_TO_BCD_300 -- requirements
Module: decimal_to_bcd_300

Interface
REQ-001 Parameter NUM_DIGITS, default 300: number of decimal digits packed per frame.
REQ-002 Parameter IDX_W, default 9: width of the digit index and count; it SHALL satisfy 2^IDX_W > NUM_DIGITS.
REQ-003 Port clk, input, 1: sole clock; all state SHALL update on the rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port clr, input, 1: synchronous frame abort/restart.
REQ-006 Port in_valid, input, 1: in_dec holds a digit.
REQ-007 Port in_dec, input, 4: decimal digit value.
REQ-008 Port in_ready, output, 1: block accepts a digit this cycle.
REQ-009 Port bcd, output, 4*NUM_DIGITS: packed BCD frame; digit k SHALL occupy bcd[4k+3:4k].
REQ-010 Port bcd_valid, output, 1: a complete frame is held on bcd.
REQ-011 Port out_ack, input, 1: the consumer has taken the frame.
REQ-012 Port digit_cnt, output, IDX_W: number of digits accepted in the current frame.
REQ-013 Port err, output, 1: sticky flag set by an invalid digit in the current frame.

Function
REQ-014 The block SHALL have two states: FILL and FULL.
REQ-015 in_ready SHALL be combinational and SHALL equal (state==FILL && !clr).
REQ-016 Accept: on an edge with in_valid && in_ready, the block SHALL write the digit to bcd[4*digit_cnt +: 4] and increment digit_cnt by 1.
REQ-017 Digit mapping: if in_dec <= 9, the block SHALL store in_dec; if in_dec >= 10, it SHALL store 4'd0 and set err (when enabled, see REQ-029).
REQ-018 The FILL-to-FULL transition SHALL occur on the edge that accepts the digit with digit_cnt==NUM_DIGITS-1.
REQ-019 From that edge: digit_cnt SHALL hold NUM_DIGITS, bcd_valid SHALL be 1, and in_ready SHALL be 0 (latency 1 cycle from the last accept to bcd_valid).
REQ-020 In FULL, bcd, digit_cnt and err SHALL be held stable until out_ack is sampled high.
REQ-021 An out_ack sample in FULL SHALL return the block to FILL with bcd_valid=0, digit_cnt=0 and err=0; bcd SHALL retain its old contents until each field is overwritten.
REQ-022 out_ack SHALL be ignored in FILL.
REQ-023 in_valid with in_ready=0 SHALL not alter any state; the producer holds its digit.
REQ-024 clr, in either state, SHALL on the next edge force state FILL, digit_cnt=0, bcd_valid=0, err=0 and bcd=0.
REQ-025 clr SHALL take priority over a simultaneous accept and over a simultaneous out_ack; the digit presented in that cycle SHALL be dropped.
REQ-026 digit_cnt SHALL never exceed NUM_DIGITS and SHALL never wrap.

Reset
REQ-027 While reset_n=0, the block SHALL immediately hold: state FILL, bcd=0, bcd_valid=0, digit_cnt=0, err=0.
REQ-028 Assertion of reset_n mid-frame SHALL discard the partial frame; after deassertion, the first accepted digit SHALL land in bcd[3:0].

Configuration
REQ-029 Macro DEC2BCD_ERR_EN: when defined, err SHALL behave per REQ-013, REQ-017, REQ-021 and REQ-024.
REQ-030 When DEC2BCD_ERR_EN is undefined, err SHALL be tied to 0 and no error flop SHALL exist; invalid digits SHALL still be stored as 0.

Verification
REQ-031 Reset, then 300 accepts of digits (k mod 10) with in_valid held high -> bcd_valid=1 exactly one cycle after the 300th accept; bcd[3:0]=0, bcd[39:36]=9, bcd[1199:1196]=9 (digit 299); digit_cnt=300; err=0.
REQ-032 Frame with in_dec=4'hC at digit 5, other digits 7 -> bcd[23:20]=0 and err=1 until out_ack; with DEC2BCD_ERR_EN undefined, err stays 0.
REQ-033 Full frame with out_ack withheld 20 cycles while in_valid stays high -> in_ready=0 throughout, bcd unchanged; out_ack pulse -> next cycle in_ready=1, digit_cnt=0, bcd_valid=0.
REQ-034 After 150 digits, assert clr together with in_valid=1 and in_dec=3 -> next cycle digit_cnt=0, bcd=0, and the digit 3 is not stored.
REQ-035 Drop reset_n asynchronously between edges after 42 digits -> outputs zero before the next edge; a fresh 300-digit frame then completes correctly.
REQ-036 Randomized in_valid gaps (about 50% duty) over 3 back-to-back frames -> each frame bit-exact against the model; no digit lost or duplicated.
